// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory-port arbiter and its scan address generator.
package mem_arb_pkg;

  localparam logic [18:0] IMG_BASE  = 19'h10000;
  localparam int          IMG_W     = 256;
  localparam int          Q_DIM     = 128;
  localparam int          FRAME_PIX = Q_DIM * Q_DIM;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  function automatic logic is_one_hot4(input logic [3:0] v);
    return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
  endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Quadrant scan address generator: x/y counters plus the latched quadrant offset.
module scan_addr_gen
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        xoff_sel,
  input  logic        yoff_sel,
  input  logic        advance,
  output logic [18:0] addr,
  output logic        all_issued
);

  logic [6:0] x;
  logic [6:0] y;
  logic       xoff_hi;
  logic       yoff_hi;
  logic [18:0] col;
  logic [18:0] row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x          <= 7'd0;
      y          <= 7'd0;
      xoff_hi    <= 1'b0;
      yoff_hi    <= 1'b0;
      all_issued <= 1'b0;
    end else if (start) begin
      x          <= 7'd0;
      y          <= 7'd0;
      xoff_hi    <= xoff_sel;
      yoff_hi    <= yoff_sel;
      all_issued <= 1'b0;
    end else if (advance && !all_issued) begin
      x <= x + 7'd1;
      if (x == 7'd127) begin
        y <= y + 7'd1;
        if (y == 7'd127) begin
          all_issued <= 1'b1;
        end
      end
    end
  end

  // Offsets of 128 are just the top counter bit; the sum wraps at 2^19.
  always_comb begin
    col  = {11'd0, xoff_hi, x};
    row  = {11'd0, yoff_hi, y};
    addr = IMG_BASE + (row * 19'(IMG_W)) + col;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU MEM stage and a quadrant display scanner.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [18:0] cpu_wdata,
  output logic [18:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        disp_start,
  input  logic [3:0]  cuadrante,
  input  logic        pix_ready,
  output logic [7:0]  pixel,
  output logic        pix_valid,
  output logic        scan_busy,
  output logic        frame_done,
  output logic [18:0] ram_addr,
  output logic        ram_we,
  output logic [18:0] ram_wdata,
  input  logic [18:0] ram_rdata
);

  scan_state_t state;
  logic        rr_cpu_last;
  logic        rd_pending;
  logic        skid_valid;
  logic [7:0]  skid_data;
  logic [13:0] pix_cnt;
  logic        cpu_rd_pending;
  logic [18:0] cpu_rdata_hold;
  logic [18:0] scan_addr;
  logic        all_issued;
  logic        start_ok;
  logic        pix_free;
  logic        disp_req;
  logic        cpu_grant;
  logic        disp_grant;
  logic        handshake;
  logic        last_pixel;

  assign start_ok   = (state == IDLE) && disp_start && is_one_hot4(cuadrante);
  assign pix_free   = !pix_valid || pix_ready;
  assign handshake  = pix_valid && pix_ready;
  assign last_pixel = handshake && (pix_cnt == 14'(FRAME_PIX - 1));
  // The skid slot catches a read already in flight when backpressure appears.
  assign disp_req   = (state == SCAN) && !all_issued && pix_free && !skid_valid;
  assign cpu_grant  = cpu_req && (!disp_req || !rr_cpu_last);
  assign disp_grant = disp_req && !cpu_grant;
  assign cpu_stall  = cpu_req && !cpu_grant;
  assign cpu_rdata  = cpu_rd_pending ? ram_rdata : cpu_rdata_hold;

  scan_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .start      (start_ok),
    .xoff_sel   (cuadrante[1] | cuadrante[3]),
    .yoff_sel   (cuadrante[2] | cuadrante[3]),
    .advance    (disp_grant),
    .addr       (scan_addr),
    .all_issued (all_issued)
  );

  always_comb begin
    ram_addr  = 19'd0;
    ram_we    = 1'b0;
    ram_wdata = 19'd0;
    if (!reset && cpu_grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end else if (!reset && disp_grant) begin
      ram_addr = scan_addr;
    end else begin
      ram_addr = 19'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      scan_busy  <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= 14'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= SCAN;
            scan_busy <= 1'b1;
            pix_cnt   <= 14'd0;
          end
        end
        SCAN: begin
          if (handshake) begin
            pix_cnt <= pix_cnt + 14'd1;
          end
          if (last_pixel) begin
            state      <= IDLE;
            scan_busy  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_cpu_last    <= 1'b0;
      cpu_rd_pending <= 1'b0;
      cpu_rdata_hold <= 19'd0;
    end else begin
      if (cpu_req && disp_req) begin
        rr_cpu_last <= cpu_grant;
      end
      cpu_rd_pending <= cpu_grant && !cpu_we;
      if (cpu_rd_pending) begin
        cpu_rdata_hold <= ram_rdata;
      end
    end
  end

  // Read data lands one cycle after the grant, into the output or the skid slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      pixel      <= 8'd0;
      pix_valid  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= 8'd0;
    end else begin
      rd_pending <= disp_grant;
      if (rd_pending) begin
        if (pix_free) begin
          pix_valid <= 1'b1;
          if (skid_valid) begin
            pixel     <= skid_data;
            skid_data <= ram_rdata[7:0];
          end else begin
            pixel <= ram_rdata[7:0];
          end
        end else begin
          skid_data  <= ram_rdata[7:0];
          skid_valid <= 1'b1;
        end
      end else if (pix_free) begin
        if (skid_valid) begin
          pixel      <= skid_data;
          pix_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          pix_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: RAM model, pixel scoreboard and CPU read checks.
module tb_mem_port_arbiter;

  localparam int BASE  = 32'h10000;
  localparam int PITCH = 256;
  localparam int QD    = 128;
  localparam int FRAME = QD * QD;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        disp_start;
  logic [3:0]  cuadrante;
  logic        pix_ready;
  logic [7:0]  pixel;
  logic        pix_valid, scan_busy, frame_done;
  logic [18:0] ram_addr, ram_wdata;
  logic        ram_we;
  logic [18:0] ram_rdata = 19'd0;

  logic [18:0] ram [0:524287];

  int checks = 0;
  int failures = 0;
  int k = 0;
  int xo = 0;
  int yo = 0;
  int frames = 0;
  bit fd_expect = 1'b0;
  bit rd_chk = 1'b0;
  logic [18:0] rd_exp;
  bit stalled = 1'b0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .disp_start(disp_start), .cuadrante(cuadrante), .pix_ready(pix_ready),
    .pixel(pixel), .pix_valid(pix_valid), .scan_busy(scan_busy), .frame_done(frame_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] pix_addr(input int n);
    return 19'(BASE + (n / QD + yo) * PITCH + (n % QD + xo));
  endfunction

  // One clock: check outputs at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [18:0] v;
    @(negedge clk);
    if (rd_chk) check_val("cpu_rdata", cpu_rdata, rd_exp);
    rd_chk = 1'b0;
    if (!cpu_req) check_val("stall_no_req", cpu_stall, 0);
    if (cpu_req && !cpu_stall) begin
      check_val("cpu_ram_addr", ram_addr, cpu_addr);
      check_val("cpu_ram_we", ram_we, cpu_we);
      if (cpu_we) check_val("cpu_ram_wdata", ram_wdata, cpu_wdata);
      else begin
        rd_chk = 1'b1;
        rd_exp = ram[cpu_addr];
      end
    end
    if (fd_expect) begin
      check_val("frame_done", frame_done, 1);
      check_val("busy_after_frame", scan_busy, 0);
      fd_expect = 1'b0;
      frames++;
    end else begin
      check_val("no_frame_done", frame_done, 0);
    end
    if (pix_valid && pix_ready) begin
      check_val("pix_in_frame", k < FRAME, 1);
      v = ram[pix_addr(k)];
      check_val("pixel", pixel, v[7:0]);
      k++;
      if (k == FRAME) fd_expect = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [3:0] q);
    cuadrante  = q;
    disp_start = 1'b1;
    xo = (q[1] || q[3]) ? QD : 0;
    yo = (q[2] || q[3]) ? QD : 0;
    k = 0;
    cycle();
    disp_start = 1'b0;
    cuadrante  = 4'($urandom);
  endtask

  task automatic cpu_random(input bit allow);
    if (!stalled) begin
      cpu_req   = allow && ($urandom_range(0, 3) == 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 19'($urandom_range(0, 32'hFFFF));
      cpu_wdata = 19'($urandom);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bit burst_done;
    logic [7:0] held;
    for (int i = 0; i < 524288; i++) ram[i] = 19'((i * 32'd2654435761) >> 11);
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 19'd0; cpu_wdata = 19'd0;
    disp_start = 1'b0; cuadrante = 4'd0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cpu_rdata", cpu_rdata, 0);
    check_val("rst_pixel", pixel, 0);
    check_val("rst_pix_valid", pix_valid, 0);
    check_val("rst_scan_busy", scan_busy, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_ram_we", ram_we, 0);
    check_val("rst_ram_addr", ram_addr, 0);
    check_val("rst_ram_wdata", ram_wdata, 0);
    check_val("rst_stall", cpu_stall, 0);
    reset = 1'b0;
    cycle();

    // CPU-only read of a fixed address, then random write/read-back pairs
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00123;
    #1;
    check_val("cpu_only_addr", ram_addr, 19'h00123);
    check_val("cpu_only_stall", cpu_stall, 0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      cpu_we = 1'b1; cpu_addr = 19'($urandom_range(0, 32'hFFFF)); cpu_wdata = 19'($urandom);
      cycle();
      cpu_we = 1'b0;
      cycle();
    end
    cpu_req = 1'b0;
    cycle();

    // Non-one-hot start is ignored
    disp_start = 1'b1; cuadrante = 4'b0011;
    cycle();
    disp_start = 1'b0;
    cycle();
    check_val("bad_start_busy", scan_busy, 0);
    check_val("bad_start_valid", pix_valid, 0);

    // Fresh round-robin state, scan quadrant (128,128)
    pulse_reset();
    pix_ready = 1'b1;
    start_scan(4'b1000);
    check_val("scan_busy_on", scan_busy, 1);
    #1;
    check_val("first_addr", ram_addr, 19'h18080);
    cycle();
    #1;
    check_val("second_addr", ram_addr, 19'h18081);
    cycle();

    // Continuous CPU demand: CPU wins first, then strict alternation
    stalled = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0;
      if (!stalled) cpu_addr = 19'($urandom_range(0, 32'hFFFF));
      if (i == 10) begin disp_start = 1'b1; cuadrante = 4'b0001; end
      else disp_start = 1'b0;
      #1;
      check_val("alt_stall", cpu_stall, (i % 2) == 1);
      stalled = cpu_stall;
      cycle();
    end
    disp_start = 1'b0;

    // Random traffic and backpressure until the frame finishes
    burst_done = 1'b0;
    for (int n = 0; n < 60000 && frames < 1; n++) begin
      if (!burst_done && k >= 5000 && pix_valid) begin
        burst_done = 1'b1;
        held = pixel;
        for (int j = 0; j < 5; j++) begin
          if (j > 0 || !stalled) cpu_req = 1'b0;
          pix_ready = 1'b0;
          #1;
          check_val("bp_valid", pix_valid, 1);
          check_val("bp_hold", pixel, held);
          cycle();
        end
        cpu_req = 1'b0;
        stalled = 1'b0;
      end
      cpu_random(1'b1);
      pix_ready = $urandom_range(0, 9) != 0;
      #1;
      stalled = cpu_stall;
      cycle();
    end
    check_val("scan1_frames", frames, 1);
    check_val("scan1_pixels", k, FRAME);
    check_val("scan1_busy", scan_busy, 0);
    check_val("bp_happened", burst_done, 1);
    cpu_req = 1'b0; stalled = 1'b0;

    // Abort a scan with reset after pixel 100
    pix_ready = 1'b1;
    start_scan(4'b0100);
    for (int n = 0; n < 2000 && k < 100; n++) cycle();
    check_val("abort_reached", k >= 100, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("abort_cpu_rdata", cpu_rdata, 0);
    check_val("abort_pixel", pixel, 0);
    check_val("abort_pix_valid", pix_valid, 0);
    check_val("abort_scan_busy", scan_busy, 0);
    check_val("abort_frame_done", frame_done, 0);
    check_val("abort_ram_we", ram_we, 0);
    check_val("abort_ram_addr", ram_addr, 0);
    check_val("abort_ram_wdata", ram_wdata, 0);
    rd_chk = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Restart at quadrant (0,0) and run to completion
    start_scan(4'b0001);
    #1;
    check_val("restart_addr", ram_addr, 19'h10000);
    for (int n = 0; n < 60000 && frames < 2; n++) begin
      pix_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    check_val("scan2_frames", frames, 2);
    check_val("scan2_pixels", k, FRAME);
    cycle();
    check_val("final_busy", scan_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
